// File: rtl/clause_queue.sv
// ---------------------------------------------------------------------------
// clause_queue
//   Per-engine clause FIFO that sits after the clause arbiter. It accepts one
//   clause per cycle while its grant bit is high and tells the arbiter when it
//   is full. The head clause is presented first-word-fall-through to the BCP
//   engine over a valid/ready handshake.
//
//   Ports
//     clock            rising-edge clock
//     reset            synchronous, active-low
//     grant_in         enqueue request (arbiter grant bit)
//     clause_in        clause to store, valid while grant_in=1
//     full_out         queue cannot accept; feeds the arbiter full_in bit
//     clause_out       head clause, 0 when the queue is empty
//     clause_valid_out head clause valid (queue non-empty)
//     deq_ready_in     engine takes the head when clause_valid_out=1
//     count_out        occupancy, 0..DEPTH
//     overflow_out     sticky: a grant arrived while no slot was left
//
//   Build option
//     CLAUSE_QUEUE_ALMOST_FULL_EN  full_out rises at DEPTH-1 so an arbiter that
//                                  registers full_in still has one slot of
//                                  slack; a grant at DEPTH-1 is still stored.
// ---------------------------------------------------------------------------
module clause_queue #(
  parameter int CLAUSE_WIDTH    = 4,
  parameter int ELEMENT_BIT_CNT = 11,
  parameter int DEPTH           = 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    grant_in,
  input  logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_in,
  output logic                                    full_out,
  output logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_out,
  output logic                                    clause_valid_out,
  input  logic                                    deq_ready_in,
  output logic [$clog2(DEPTH):0]                  count_out,
  output logic                                    overflow_out
);

  localparam int W  = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic no_room;
  logic empty;
  logic enq;
  logic deq;

  // Acceptance is decided on the true capacity, independent of where
  // full_out is advertised, so the almost-full build can still fill up.
  assign no_room = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign enq     = grant_in && !no_room;
  assign deq     = !empty && deq_ready_in;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped grant is not rescued by a dequeue in the same cycle.
    if (grant_in && no_room) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; stale words are never visible because the
  // output is masked while empty.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= clause_in;
  end

`ifdef CLAUSE_QUEUE_ALMOST_FULL_EN
  assign full_out = (count_q >= DEPTH_C - CW'(1));
`else
  assign full_out = no_room;
`endif

  assign clause_valid_out = !empty;
  assign clause_out       = empty ? '0 : mem_q[rd_ptr_q];
  assign count_out        = count_q;
  assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_clause_queue.sv
module tb_clause_queue;

  localparam int DEPTH = 8;
  localparam int W     = 44;

  logic          clock = 1'b0;
  logic          reset;
  logic          grant_in;
  logic [W-1:0]  clause_in;
  logic          full_out;
  logic [W-1:0]  clause_out;
  logic          clause_valid_out;
  logic          deq_ready_in;
  logic [3:0]    count_out;
  logic          overflow_out;

  clause_queue #(.CLAUSE_WIDTH(4), .ELEMENT_BIT_CNT(11), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .grant_in        (grant_in),
    .clause_in       (clause_in),
    .full_out        (full_out),
    .clause_out      (clause_out),
    .clause_valid_out(clause_valid_out),
    .deq_ready_in    (deq_ready_in),
    .count_out       (count_out),
    .overflow_out    (overflow_out)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // reference state: queue contents and sticky overflow flag
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic [W-1:0] obs[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_full;
`ifdef CLAUSE_QUEUE_ALMOST_FULL_EN
    exp_full = (mq.size() >= DEPTH - 1);
`else
    exp_full = (mq.size() == DEPTH);
`endif
    chk({tag, ".count"}, 64'(count_out), 64'(mq.size()));
    chk({tag, ".valid"}, 64'(clause_valid_out), 64'(mq.size() != 0));
    chk({tag, ".data"},  64'(clause_out), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk({tag, ".full"},  64'(full_out), 64'(exp_full));
    chk({tag, ".ovf"},   64'(overflow_out), 64'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic cycle(input string tag, input logic rst_n, input logic g,
                       input logic [W-1:0] d, input logic rdy);
    reset = rst_n; grant_in = g; clause_in = d; deq_ready_in = rdy;
    if (rst_n && rdy && clause_valid_out) obs.push_back(clause_out);
    @(posedge clock);
    #1;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      bit can_deq, can_enq;
      can_deq = rdy && (mq.size() > 0);
      can_enq = g && (mq.size() < DEPTH);
      if (g && mq.size() == DEPTH) m_ovf = 1'b1;
      if (can_deq) void'(mq.pop_front());
      if (can_enq) mq.push_back(d);
    end
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b0; grant_in = 1'b0; clause_in = '0; deq_ready_in = 1'b0;

    // 1. reset held with grant asserted
    cycle("rst", 1'b0, 1'b1, 44'hABC, 1'b0);
    cycle("rst", 1'b0, 1'b1, 44'hABC, 1'b0);
    chk("rst.count0", 64'(count_out), 64'd0);

    // 2. fill with no consumer
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b1, W'(i), 1'b0);
    chk("fill.count8", 64'(count_out), 64'd8);
    chk("fill.full", 64'(full_out), 64'd1);
    chk("fill.head", 64'(clause_out), 64'h001);

    // 3. grant while full is dropped, overflow sticks
    cycle("ovf", 1'b1, 1'b1, 44'hFFF_FFFF_FFFF, 1'b0);
    chk("ovf.flag", 64'(overflow_out), 64'd1);
    chk("ovf.count", 64'(count_out), 64'd8);
    obs.delete();
    for (int i = 0; i < 9; i++) cycle("drain", 1'b1, 1'b0, '0, 1'b1);
    chk("drain.n", 64'(obs.size()), 64'd8);
    for (int i = 0; i < obs.size(); i++) chk("drain.order", 64'(obs[i]), 64'(i + 1));
    chk("drain.ovf_sticky", 64'(overflow_out), 64'd1);

    // 4. wrap: 20 clauses, consumer ready every other cycle
    cycle("rst2", 1'b0, 1'b0, '0, 1'b0);
    obs.delete();
    begin
      int sent = 0;
      int cyc  = 0;
      while ((sent < 20 || mq.size() != 0) && cyc < 200) begin
        logic g;
        g = (sent < 20) && (mq.size() < DEPTH - 1);
        cycle("wrap", 1'b1, g, W'(44'h100 + sent), cyc[0]);
        if (g) sent++;
        cyc++;
      end
      chk("wrap.timeout", 64'(cyc < 200), 64'd1);
    end
    chk("wrap.n", 64'(obs.size()), 64'd20);
    for (int i = 0; i < obs.size(); i++) chk("wrap.order", 64'(obs[i]), 64'(44'h100 + i));
    chk("wrap.ovf", 64'(overflow_out), 64'd0);

    // 5. simultaneous enqueue+dequeue at count 3
    for (int i = 0; i < 3; i++) cycle("sim.pre", 1'b1, 1'b1, W'(44'h200 + i), 1'b0);
    obs.delete();
    for (int i = 3; i < 7; i++) cycle("sim", 1'b1, 1'b1, W'(44'h200 + i), 1'b1);
    chk("sim.count", 64'(count_out), 64'd3);
    for (int i = 0; i < obs.size(); i++) chk("sim.order", 64'(obs[i]), 64'(44'h200 + i));
    chk("sim.n", 64'(obs.size()), 64'd4);

    // 6. top boundary: count DEPTH-1, one more, then overflow
    cycle("af.rst", 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cycle("af.fill", 1'b1, 1'b1, W'(44'h300 + i), 1'b0);
`ifdef CLAUSE_QUEUE_ALMOST_FULL_EN
    chk("af.full7", 64'(full_out), 64'd1);
`else
    chk("af.full7", 64'(full_out), 64'd0);
`endif
    cycle("af.last", 1'b1, 1'b1, 44'h3FF, 1'b0);
    chk("af.count8", 64'(count_out), 64'd8);
    chk("af.noovf", 64'(overflow_out), 64'd0);
    // grant at DEPTH with a dequeue in the same cycle: still dropped
    cycle("af.over", 1'b1, 1'b1, 44'h3EE, 1'b1);
    chk("af.ovf", 64'(overflow_out), 64'd1);
    chk("af.count7", 64'(count_out), 64'd7);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic rst_n, g, rdy;
      logic [W-1:0] d;
      rst_n = ($urandom_range(0, 99) != 0);
      g     = ($urandom_range(0, 99) < 60);
      rdy   = ($urandom_range(0, 99) < 45);
      d     = {$urandom(), $urandom()};
      cycle("rand", rst_n, g, d, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
